// File: rtl/row_filter_k_if.sv
// rtl/row_filter_k_if.sv - input/output stream handshake bundle for row_filter_k
interface row_filter_k_if #(
  parameter int BITWIDTH = 8,
  parameter int TAPS     = 3
);
  localparam int OUT_W = 2*BITWIDTH + $clog2(TAPS);

  logic                     data_in_valid;
  logic                     data_in_ready;
  logic [TAPS*BITWIDTH-1:0] din;
  logic                     data_out_valid;
  logic                     data_out_ready;
  logic [OUT_W-1:0]         dout;

  modport master (
    output data_in_valid, din, data_out_ready,
    input  data_in_ready, data_out_valid, dout
  );

  modport slave (
    input  data_in_valid, din, data_out_ready,
    output data_in_ready, data_out_valid, dout
  );
endinterface

// File: rtl/row_filter_k.sv
// rtl/row_filter_k.sv - K-tap signed row filter, one shift-add multiplier per lane
module row_filter_k #(
  parameter  int BITWIDTH = 8,
  parameter  int TAPS     = 3,
  localparam int OUT_W    = 2*BITWIDTH + $clog2(TAPS),
  localparam int AW       = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  row_filter_k_if.slave              bus,
  input  logic                       weight_we,
  input  logic [AW-1:0]              weight_addr,
  input  logic signed [BITWIDTH-1:0] weight_data,
  input  logic                       relu_en
);
  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_OUT} state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic signed [BITWIDTH-1:0]  w_q      [TAPS];
  logic signed [BITWIDTH-1:0]  w_snap_q [TAPS];
  logic signed [BITWIDTH-1:0]  a_q      [TAPS];
  logic signed [OUT_W-1:0]     acc_q    [TAPS];
  logic signed [OUT_W-1:0]     acc_d    [TAPS];
  logic signed [OUT_W-1:0]     shifted  [TAPS];
  logic signed [OUT_W-1:0]     sum_d;
  logic signed [OUT_W-1:0]     dout_q;
  logic                        relu_q;
  logic                        out_valid_q;
  logic                        last_bit;

  // The weight MSB carries -2^(BITWIDTH-1), so the final partial product is subtracted.
  always_comb begin
    last_bit = (cnt_q == CW'(BITWIDTH-1));
    sum_d    = '0;
    for (int i = 0; i < TAPS; i++) begin
      shifted[i] = {{(OUT_W-BITWIDTH){a_q[i][BITWIDTH-1]}}, a_q[i]} << cnt_q;
      acc_d[i]   = acc_q[i];
      if (last_bit) begin
        if (w_snap_q[i][BITWIDTH-1]) acc_d[i] = acc_q[i] - shifted[i];
      end else if (w_snap_q[i][cnt_q]) begin
        acc_d[i] = acc_q[i] + shifted[i];
      end
      sum_d = sum_d + acc_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        w_q[i]      <= '0;
        w_snap_q[i] <= '0;
        a_q[i]      <= '0;
        acc_q[i]    <= '0;
      end
    end else begin
      if (weight_we && (int'(weight_addr) < TAPS)) w_q[weight_addr] <= weight_data;

      if (flush) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        cnt_q       <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.data_in_valid) begin
              // Snapshot takes the pre-write weight when a write lands on the same edge.
              for (int i = 0; i < TAPS; i++) begin
                a_q[i]      <= bus.din[i*BITWIDTH +: BITWIDTH];
                w_snap_q[i] <= w_q[i];
                acc_q[i]    <= '0;
              end
              relu_q  <= relu_en;
              cnt_q   <= '0;
              state_q <= S_MUL;
            end
          end
          S_MUL: begin
            for (int i = 0; i < TAPS; i++) acc_q[i] <= acc_d[i];
            if (last_bit) begin
              cnt_q   <= '0;
              state_q <= S_SUM;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_SUM: begin
            dout_q      <= (relu_q && sum_d[OUT_W-1]) ? '0 : sum_d;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
          S_OUT: begin
            if (bus.data_out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_in_ready  = (state_q == S_IDLE);
  assign bus.data_out_valid = out_valid_q;
  assign bus.dout           = dout_q;
endmodule
